// File: rtl/result_serializer.sv
// Buffers whole accumulator result vectors and emits them one lane per
// transfer over a valid/ready stream. Vectors arriving while full are dropped.
module result_serializer #(
  parameter int DATAW     = 32,
  parameter int NUM_LANES = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*DATAW-1:0] idata,
  input  logic                       ivalid,
  output logic                       ifull,
  output logic [DATAW-1:0]           odata,
  output logic                       ovalid,
  input  logic                       oready,
  output logic                       olast,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [NUM_LANES-1:0][DATAW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] lane_cnt;
  logic          push, xfer, pop;

  assign ifull  = (count == FULL_CNT);
  assign ovalid = (count != '0);
  assign olast  = ovalid && (lane_cnt == LAST_LANE);
  assign push   = ivalid && !ifull;
  assign xfer   = ovalid && oready;
  assign pop    = xfer && (lane_cnt == LAST_LANE);
  // Head lane is a mux of registered storage; forced to 0 when nothing is held.
  assign odata  = ovalid ? mem[rd_ptr][lane_cnt] : '0;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= idata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (ivalid && ifull) overflow <= 1'b1;
      if (xfer) lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + LW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: a reference occupancy model with a lane
// scoreboard checks every cycle, plus table-driven and directed corner cases.
module tb_result_serializer;
  localparam int DATAW = 32;
  localparam int NL    = 8;
  localparam int DEPTH = 4;

  logic                  clk, rst, ivalid, oready;
  logic [NL*DATAW-1:0]   idata;
  logic                  ifull, ovalid, olast, overflow;
  logic [DATAW-1:0]      odata;

  result_serializer #(.DATAW(DATAW), .NUM_LANES(NL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ifull(ifull),
    .odata(odata), .ovalid(ovalid), .oready(oready), .olast(olast),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATAW-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    logic             rdy;
    logic             vld;
    logic [DATAW-1:0] data;
    logic             last;
  } row_t;

  beat_t sb[$];
  beat_t mb;
  row_t  tbl [25];
  int    errors = 0, checks = 0;
  int    mcnt = 0, rx = 0, rx0 = 0;
  bit    mover = 1'b0, mon_en = 1'b0, full_now;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, evaluated half a cycle before each active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      full_now = (mcnt == DEPTH);
      chk_b("ovalid", ovalid, mcnt != 0);
      chk_b("ifull", ifull, full_now);
      chk_b("overflow", overflow, mover);
      if (rst) begin
        sb.delete();
        mcnt  = 0;
        mover = 1'b0;
      end else begin
        if (ovalid && oready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", odata, $time);
          end else begin
            mb = sb.pop_front();
            chk_d("odata", odata, mb.data);
            chk_b("olast", olast, mb.last);
            rx++;
            if (mb.last) mcnt--;
          end
        end
        if (ivalid) begin
          if (full_now) mover = 1'b1;
          else begin
            for (int k = 0; k < NL; k++) sb.push_back('{idata[k*DATAW +: DATAW], k == NL-1});
            mcnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NL*DATAW-1:0] v);
    idata  = v;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    oready = 1'b1;
    for (int n = 0; n < 200 && (sb.size() != 0 || ovalid); n++) tick();
    chk_b("drain_done", (sb.size() == 0) && !ovalid, 1'b1);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      oready = tbl[i].rdy;
      @(negedge clk);
      chk_b($sformatf("row%0d ovalid", i), ovalid, tbl[i].vld);
      chk_d($sformatf("row%0d odata", i), odata, tbl[i].data);
      chk_b($sformatf("row%0d olast", i), olast, tbl[i].last);
      tick();
    end
  endtask

  function automatic logic [NL*DATAW-1:0] mkvec(input logic [DATAW-1:0] base, input logic [DATAW-1:0] step);
    logic [NL*DATAW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*DATAW +: DATAW] = base + DATAW'(k) * step;
    return v;
  endfunction

  function automatic row_t mkrow(input logic r, input logic v, input int d, input logic l);
    row_t x;
    x.rdy  = r;
    x.vld  = v;
    x.data = DATAW'(d);
    x.last = l;
    return x;
  endfunction

  initial begin
    // Rows 0..8: steady oready; rows 9..24: oready alternating 1,0.
    for (int i = 0; i < 8; i++) tbl[i] = mkrow(1'b1, 1'b1, i + 1, i == 7);
    tbl[8] = mkrow(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 15; i++) tbl[9+i] = mkrow(i % 2 == 0, 1'b1, (i + 1) / 2 + 1, i >= 13);
    tbl[24] = mkrow(1'b1, 1'b0, 0, 1'b0);

    rst = 1'b1; ivalid = 1'b0; oready = 1'b0; idata = '0;
    tick();
    do_reset();
    @(negedge clk);
    chk_b("rst_ovalid", ovalid, 1'b0);
    chk_b("rst_ifull", ifull, 1'b0);
    chk_b("rst_olast", olast, 1'b0);
    chk_b("rst_overflow", overflow, 1'b0);
    mon_en = 1'b1;
    tick();

    // Single vector, free-flowing output.
    oready = 1'b1;
    push(mkvec(32'd1, 32'd1));
    run_rows(0, 8);

    // Same vector under alternating backpressure.
    push(mkvec(32'd1, 32'd1));
    run_rows(9, 24);

    // Signed lanes crossing zero pass bit-exact.
    push(mkvec(32'hFFFF_FFFC, 32'd1));
    drain();

    // Wrap-around streaming: one vector every 8 cycles.
    rx0 = rx;
    oready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      push(mkvec(32'h1000 * (v + 1), 32'd1));
      repeat (7) tick();
    end
    drain();
    chk_d("wrap_lanes", DATAW'(rx - rx0), 32'd96);
    chk_b("wrap_overflow", overflow, 1'b0);

    // Push on a popping edge while full is dropped; with count=3 it is taken.
    oready = 1'b0;
    for (int v = 0; v < 4; v++) push(mkvec(32'hA000 + 32'h100 * v, 32'd1));
    chk_b("pp_full", ifull, 1'b1);
    oready = 1'b1;
    repeat (7) tick();
    push(mkvec(32'hE000, 32'd1));
    chk_b("pp_drop_ovf", overflow, 1'b1);
    chk_b("pp_drop_ifull", ifull, 1'b0);
    repeat (7) tick();
    push(mkvec(32'hF000, 32'd1));
    chk_b("pp_keep_ifull", ifull, 1'b0);
    chk_b("pp_keep_ovalid", ovalid, 1'b1);
    oready = 1'b0;
    push(mkvec(32'hC000, 32'd1));
    chk_b("pp_refill_ifull", ifull, 1'b1);
    drain();
    do_reset();

    // Fill to overflow with output stalled.
    oready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      push(mkvec(32'h10 + DATAW'(t), 32'h10000));
      if (t == 3) chk_b("fill_ifull", ifull, 1'b1);
    end
    chk_b("fill_overflow", overflow, 1'b1);
    drain();
    chk_b("fill_sticky", overflow, 1'b1);

    // Reset mid-vector after lanes 0..3 have gone.
    oready = 1'b1;
    push(mkvec(32'h3000, 32'd1));
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_b("mid_rst_ovalid", ovalid, 1'b0);
    chk_b("mid_rst_ifull", ifull, 1'b0);
    chk_b("mid_rst_overflow", overflow, 1'b0);
    push(mkvec(32'h4000, 32'd1));
    chk_d("mid_rst_lane0", odata, 32'h4000);
    chk_b("mid_rst_olast", olast, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
- REQ-001: Parameter DATAW, default 32, width of one accumulator result lane.
- REQ-002: Parameter NUM_LANES, default 8, number of parallel accum output lanes packed per input vector.
- REQ-003: Parameter DEPTH, default 4, number of whole input vectors buffered; power of two, >= 2.
- REQ-004: clk  input  1  single clock; all logic on rising edge.
- REQ-005: rst  input  1  synchronous, active-high reset.
- REQ-006: idata  input  NUM_LANES*DATAW  packed accum results; lane k = bits [(k+1)*DATAW-1 : k*DATAW].
- REQ-007: ivalid  input  1  idata is valid this cycle; driven by the accum ovalid signals, all lanes aligned.
- REQ-008: ifull  output  1  buffer holds DEPTH vectors; the next push is dropped.
- REQ-009: odata  output  DATAW  current lane of the head vector.
- REQ-010: ovalid  output  1  odata is valid.
- REQ-011: oready  input  1  downstream accepts odata this cycle.
- REQ-012: olast  output  1  odata is lane NUM_LANES-1 of its vector.
- REQ-013: overflow  output  1  sticky flag: at least one vector was dropped since reset.

Function
- REQ-014: Storage is a circular buffer of DEPTH entries, each NUM_LANES*DATAW bits, with a write pointer, a read pointer and an occupancy count of width $clog2(DEPTH)+1.
- REQ-015: Push: on a rising edge with ivalid=1 and ifull=0, idata is written at the write pointer, and the write pointer and count are incremented.
- REQ-016: Drop: on a rising edge with ivalid=1 and ifull=1, idata is discarded, no state other than overflow changes, and overflow is set to 1.
- REQ-017: overflow stays at 1 until rst; nothing else clears it.
- REQ-018: ifull = (count == DEPTH), taken from the registered count.
  - A push while ifull=1 is dropped even if a pop occurs in the same cycle.
- REQ-019: ovalid = (count != 0), taken from registered state.
  - A vector pushed at edge t is first presented at odata during the cycle after edge t (1-cycle latency).
- REQ-020: A lane counter (0..NUM_LANES-1) selects odata = lane[lane_cnt] of the head entry.
  - odata is a combinational mux of registered storage.
- REQ-021: Handshake: a transfer occurs on a rising edge with ovalid=1 and oready=1.
  - odata, olast and ovalid hold stable while ovalid=1 and oready=0.
- REQ-022: On a transfer with lane_cnt < NUM_LANES-1, lane_cnt increments and the entry is retained.
- REQ-023: On a transfer with lane_cnt = NUM_LANES-1, the following happens on the same edge:
  - lane_cnt returns to 0;
  - the read pointer increments (pop);
  - count decrements.
- REQ-024: olast = ovalid AND (lane_cnt == NUM_LANES-1).
- REQ-025: A push and a pop on the same edge leave count unchanged; both pointers advance.
- REQ-026: Both pointers wrap from DEPTH-1 to 0.
- REQ-027: oready while ovalid=0 has no effect.
- REQ-028: The block performs no arithmetic on data; lanes are passed bit-exact, with signedness preserved.

Reset
- REQ-029: Under rst=1 at a rising edge, the following reset to 0: write pointer, read pointer, count, lane_cnt, overflow.
  - Consequently ovalid=0, olast=0 and ifull=0 from the next cycle.
- REQ-030: Storage contents are not reset.
  - odata is don't-care while ovalid=0; the bench treats it as 0 only as a convention.
- REQ-031: rst has priority over a simultaneous push or transfer.
  - Reset asserted mid-vector discards all buffered data and any partially sent vector.

Verification
- REQ-032: Single vector, lanes 0..7 = 1..8, oready=1 constantly:
  - ovalid is high from cycle t+1 for 8 cycles;
  - odata is 1,2,...,8;
  - olast is high only with value 8;
  - then ovalid=0.
- REQ-033: Backpressure, same vector, oready toggling 1,0,1,0:
  - odata holds its value for every cycle in which oready=0;
  - the sequence 1..8 is delivered with no loss or duplication.
- REQ-034: Fill with oready=0 while pushing 5 vectors tagged 0x10..0x14 in lane 0:
  - ifull=1 after the 4th push;
  - the 5th push is dropped and overflow=1;
  - draining yields lane-0 values 0x10..0x13 only;
  - overflow stays 1.
- REQ-035: Simultaneous push/pop, with count=4 (ifull=1), oready=1 and the head at lane 7:
  - a push on the popping edge is dropped;
  - with count=3, the same push is accepted and count stays 3.
- REQ-036: Wrap-around: stream 12 vectors with oready=1, pushing one vector every 8 cycles:
  - all 96 lanes arrive in order;
  - overflow=0.
- REQ-037: Reset mid-vector: assert rst after lane 3 of a vector has transferred:
  - the next cycle shows ovalid=0, ifull=0, overflow=0;
  - a new vector 0x4000,... is then delivered starting at lane 0.
